// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, FSM states, queue entry type and end-of-program marker for instruction fetch
package fetch_pkg;
    localparam int MEM_WORDS_DEF = 1280;
    localparam int QDEPTH_DEF = 2;
    localparam logic [31:0] HALT_INSTR = 32'h0;
    typedef enum logic [1:0] {
        FETCH,
        HALT,
        FAULT
    } state_e;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched {instr, pc} entries with flush
//   clk, rst     clock and synchronous active-high reset
//   flush        drop every entry and rewind pointers
//   push, wdata  enqueue request; accepted when not full or when popping the same cycle
//   pop, rdata   dequeue request and head entry (zero when empty)
//   full, empty  occupancy flags
module fetch_queue import fetch_pkg::*; #(
    parameter int QDEPTH = QDEPTH_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);
    localparam int PW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    entry_t mem_q [QDEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign full    = count_q == CW'(QDEPTH);
    assign empty   = count_q == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[head_q];
    always_comb begin
        head_d  = flush ? '0 : do_pop ? inc(head_q) : head_q;
        tail_d  = flush ? '0 : do_push ? inc(tail_q) : tail_q;
        count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    // Storage needs no reset: reads are masked to zero while empty.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem_q[tail_q] <= wdata;
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencer feeding a fetch queue, with redirect, halt on zero word and bounds fault
//   clk, rst                      clock and synchronous active-high reset
//   imem_addr, imem_instr         word address out, combinational instruction back
//   redirect_valid, redirect_pc   flush the queue and restart fetch at redirect_pc
//   out_valid, out_ready          head handshake toward decode
//   out_instr, out_pc             head instruction and its word index
//   halted, fault                 FSM status: zero word fetched / PC out of memory (sticky)
module instruction_fetch import fetch_pkg::*; #(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int QDEPTH = QDEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        fault
);
    state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic redirect, in_range, is_halt, push, pop, full, empty;
    entry_t head;
    // A fault is terminal until reset, so redirects are ignored there.
    assign redirect  = redirect_valid && state_q != FAULT;
    assign in_range  = pc_q < 32'(MEM_WORDS);
    assign is_halt   = imem_instr == HALT_INSTR;
    assign pop       = out_valid && out_ready && !redirect;
    assign push      = state_q == FETCH && in_range && !is_halt && (!full || pop) && !redirect;
    assign imem_addr = pc_q;
    assign out_valid = !empty;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign halted    = state_q == HALT;
    assign fault     = state_q == FAULT;
    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .wdata ('{instr: imem_instr, pc: pc_q}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect) begin
            state_d = FETCH;
            pc_d    = redirect_pc;
        end else if (state_q == FETCH) begin
            if (!in_range) state_d = FAULT;
            else if (is_halt) state_d = HALT;
            else if (push) pc_d = pc_q + 32'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of fetch sequencing, backpressure, redirect, halt, fault and reset
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst, redirect_valid, out_ready, out_valid, halted, fault;
    logic [31:0] imem_addr, imem_instr, redirect_pc, out_instr, out_pc;
    logic [31:0] mem [2048];
    int chk_cnt = 0;
    int pass_cnt = 0;
    always #5 clk = ~clk;
    assign imem_instr = mem[imem_addr[10:0]];
    instruction_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fault          (fault)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else pass_cnt++;
    endtask
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 32'hA000_0000 | i;
        mem[12] = '0;
        tick;
        tick;
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_addr", imem_addr, 0);
        out_ready = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            chk("run_valid", out_valid, 1);
            chk("run_pc", out_pc, i);
            chk("run_instr", out_instr, 32'hA000_0000 | i);
            chk("run_halted", halted, 0);
        end
        tick;
        chk("halt_halted", halted, 1);
        chk("halt_valid", out_valid, 0);
        tick;
        chk("halt_addr", imem_addr, 12);
        chk("halt_hold", halted, 1);
        redirect_valid = 1'b1;
        redirect_pc = 32'd3;
        tick;
        redirect_valid = 1'b0;
        chk("rdh_halted", halted, 0);
        chk("rdh_valid", out_valid, 0);
        chk("rdh_addr", imem_addr, 3);
        tick;
        chk("rdh_out_valid", out_valid, 1);
        chk("rdh_out_pc", out_pc, 3);
        rst = 1'b1;
        out_ready = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        tick;
        tick;
        chk("bp_valid", out_valid, 1);
        chk("bp_pc", out_pc, 0);
        chk("bp_addr", imem_addr, 2);
        tick;
        chk("bp_addr_hold", imem_addr, 2);
        chk("bp_pc_hold", out_pc, 0);
        out_ready = 1'b1;
        tick;
        chk("bp_drain1", out_pc, 1);
        tick;
        chk("bp_drain2", out_pc, 2);
        out_ready = 1'b0;
        tick;
        chk("full_addr", imem_addr, 4);
        chk("full_pc", out_pc, 2);
        redirect_valid = 1'b1;
        redirect_pc = 32'd9;
        tick;
        redirect_valid = 1'b0;
        chk("rdf_valid", out_valid, 0);
        chk("rdf_addr", imem_addr, 9);
        tick;
        chk("rdf_out_valid", out_valid, 1);
        chk("rdf_out_pc", out_pc, 9);
        tick;
        chk("rq_pc", out_pc, 9);
        chk("rq_addr", imem_addr, 11);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rq_valid", out_valid, 0);
        chk("rq_addr0", imem_addr, 0);
        tick;
        chk("rq_first_valid", out_valid, 1);
        chk("rq_first_pc", out_pc, 0);
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd1279;
        tick;
        redirect_valid = 1'b0;
        chk("end_addr", imem_addr, 1279);
        chk("end_valid", out_valid, 0);
        tick;
        chk("end_out_valid", out_valid, 1);
        chk("end_out_pc", out_pc, 1279);
        chk("end_no_fault", fault, 0);
        tick;
        chk("flt_fault", fault, 1);
        chk("flt_valid", out_valid, 0);
        chk("flt_addr", imem_addr, 1280);
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        tick;
        redirect_valid = 1'b0;
        chk("flt_rd_fault", fault, 1);
        chk("flt_rd_valid", out_valid, 0);
        chk("flt_rd_addr", imem_addr, 1280);
        tick;
        chk("flt_stay_valid", out_valid, 0);
        chk("flt_stay_fault", fault, 1);
        rst = 1'b1;
        tick;
        chk("flt_rst_fault", fault, 0);
        chk("flt_rst_addr", imem_addr, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1280, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter QDEPTH, default 2, meaning fetch-queue entries.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port imem_addr, output, 32, word index driven to instruction memory; equals PC.
REQ-006 SHALL have port imem_instr, input, 32, instruction returned combinationally for imem_addr in the same cycle.
REQ-007 SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32, redirect target word index.
REQ-009 SHALL have port out_valid, output, 1, queue head valid toward decode.
REQ-010 SHALL have port out_ready, input, 1, decode accepts the head this cycle.
REQ-011 SHALL have port out_instr, output, 32, instruction at queue head.
REQ-012 SHALL have port out_pc, output, 32, word index of out_instr.
REQ-013 SHALL have port halted, output, 1, a zero instruction was fetched and fetching has stopped.
REQ-014 SHALL have port fault, output, 1, PC reached or passed MEM_WORDS; sticky until reset.

Function
REQ-015 SHALL implement states FETCH, HALT and FAULT; halted=(state==HALT) and fault=(state==FAULT).
REQ-016 SHALL, in FETCH with PC<MEM_WORDS, enqueue {imem_instr, PC} and set PC<=PC+1 when count<QDEPTH, or when count==QDEPTH and the head is dequeued that cycle.
REQ-017 SHALL treat imem_instr==32'h0 as end of program: no enqueue, PC holds, FETCH->HALT.
REQ-018 SHALL, in FETCH with PC>=MEM_WORDS, perform no enqueue and transition to FAULT.
REQ-019 SHALL dequeue the head when out_valid&&out_ready; out_valid=(count!=0).
REQ-020 SHALL have latency of one cycle: an instruction enqueued at edge N appears on out_* after edge N when the queue was empty.
REQ-021 SHALL, on redirect_valid in FETCH or HALT, flush all queue entries, set PC<=redirect_pc, enter FETCH, and suppress any enqueue or dequeue in that cycle.
REQ-022 SHALL ignore redirect_valid in FAULT.
REQ-023 SHALL keep imem_addr stable while the queue is full and no dequeue occurs.
REQ-024 SHALL keep queue order FIFO, with head/tail pointers wrapping modulo QDEPTH.
REQ-025 SHALL perform PC arithmetic as 32-bit unsigned; MEM_WORDS bounds the comparison.

Reset
REQ-026 SHALL, while rst is high at a clock edge, set PC=0, count=0, pointers=0, state=FETCH; out_valid=0, out_instr=0, out_pc=0, halted=0, fault=0.
REQ-027 SHALL give rst priority over redirect, enqueue and dequeue; reset mid-operation discards all queued entries.

Structure
REQ-028 SHALL place MEM_WORDS default, QDEPTH default, the state enum and the HALT_INSTR constant (32'h0) in a shared package fetch_pkg.
REQ-029 SHALL implement the queue as sub-module fetch_queue, a synchronous FIFO with flush, push, pop, full and empty, parameterised by QDEPTH.

Verification
REQ-030 SHALL cover this case: memory words 0..11 non-zero, word 12 zero, out_ready=1 -> out_pc 0..11 in consecutive cycles, then halted=1 and out_valid=0 after drain.
REQ-031 SHALL cover backpressure: out_ready=0 from reset -> two entries (pc 0,1) are queued and imem_addr holds at 2; raise out_ready -> out_pc 0,1,2 in order with no loss.
REQ-032 SHALL cover redirect while full to redirect_pc=9 -> next cycle out_valid=0 and imem_addr=9; following cycle out_pc=9.
REQ-033 SHALL cover redirect while halted to 3 -> halted=0, fetch resumes, out_pc=3.
REQ-034 SHALL cover redirect to 1279 with non-zero word -> out_pc=1279 delivered, then fault=1; a later redirect leaves fault=1 and out_valid stays 0 after drain.
REQ-035 SHALL cover rst asserted with 2 entries queued -> next cycle out_valid=0 and imem_addr=0; first post-reset out_pc=0.
